// File: rtl/hello_scroll_ctrl_if.sv
// Control and position bus between the HELLO scroll controller and its board-side neighbours.
// Latency: none, plain wires.
// Backpressure: none, level signals plus a one-cycle tick strobe.
`timescale 1ns/1ps
interface hello_scroll_ctrl_if #(
    parameter int POS_W = 4
);
    logic             run_sw;
    logic             dir_sw;
    logic [1:0]       speed;
    logic             step_key_n;
    logic [POS_W-1:0] pos;
    logic             tick;
    logic [1:0]       state;

    // Switch/button side drives the controls and watches the position.
    modport master (
        output run_sw, dir_sw, speed, step_key_n,
        input  pos, tick, state
    );

    // Scroll controller side.
    modport slave (
        input  run_sw, dir_sw, speed, step_key_n,
        output pos, tick, state
    );
endinterface

// File: rtl/hello_scroll_ctrl.sv
// Scroll position generator for the eight-digit HELLO display: run/pause, direction, speed, single step.
// Latency: pin changes reach the FSM 3 cycles later; pos and tick update together on each advance.
// Backpressure: none; optional ping-pong mode enabled by defining HELLO_SCROLL_BOUNCE_EN.
`timescale 1ns/1ps
module hello_scroll_ctrl #(
    parameter int TICK_CYCLES = 50000000,
    parameter int NPOS        = 8,
    parameter int POS_W       = 4,
    parameter int PRE_W       = 26
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    hello_scroll_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'b00,
        ST_RUNNING = 2'b01,
        ST_STEP    = 2'b10
    } state_t;

    localparam logic [PRE_W-1:0] TICK_P   = PRE_W'(TICK_CYCLES);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NPOS - 1);

    // Synchroniser stages
    logic       run_s1_q, run_s2_q;
    logic [1:0] speed_s1_q, speed_s2_q;
    logic       step_s1_q, step_s2_q, step_prev_q, step_edge_q;

    // FSM state and registered outputs
    state_t           state_q;
    logic [POS_W-1:0] pos_q;
    logic             tick_q;
    logic [PRE_W-1:0] pre_q;

    // Combinational helpers
    logic [PRE_W-1:0] lim_raw_d, lim_d;
    logic             wrap_d;
    logic             adv_en_d;
    logic [POS_W-1:0] pos_adv_d;

    // Two-flop synchronisers; the step button idles high, so its chain resets to 1.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            run_s1_q    <= 1'b0;
            run_s2_q    <= 1'b0;
            speed_s1_q  <= 2'b00;
            speed_s2_q  <= 2'b00;
            step_s1_q   <= 1'b1;
            step_s2_q   <= 1'b1;
            step_prev_q <= 1'b1;
            step_edge_q <= 1'b0;
        end else begin
            run_s1_q    <= bus.run_sw;
            run_s2_q    <= run_s1_q;
            speed_s1_q  <= bus.speed;
            speed_s2_q  <= speed_s1_q;
            step_s1_q   <= bus.step_key_n;
            step_s2_q   <= step_s1_q;
            step_prev_q <= step_s2_q;
            step_edge_q <= step_prev_q & ~step_s2_q;
        end
    end

    // Prescaler limit; a shift that underflows to zero is clamped to one cycle.
    // The >= compare lets a speed-up mid-count wrap on the very next cycle.
    always_comb begin
        lim_raw_d = TICK_P >> speed_s2_q;
        lim_d     = (lim_raw_d == '0) ? PRE_W'(1) : lim_raw_d;
        wrap_d    = (pre_q >= (lim_d - PRE_W'(1)));
    end

    // Advance happens either on a single step from PAUSED or on a wrap while still running.
    always_comb begin
        adv_en_d = ((state_q == ST_PAUSED)  && !run_s2_q && step_edge_q) ||
                   ((state_q == ST_RUNNING) &&  run_s2_q && wrap_d);
    end

`ifdef HELLO_SCROLL_BOUNCE_EN
    logic dir_q;
    logic dir_adv_d;

    // Ping-pong: turn around at either end instead of wrapping.
    always_comb begin
        pos_adv_d = pos_q;
        dir_adv_d = dir_q;
        if (!dir_q) begin
            if (pos_q == POS_LAST) begin
                pos_adv_d = POS_LAST - POS_W'(1);
                dir_adv_d = 1'b1;
            end else begin
                pos_adv_d = pos_q + POS_W'(1);
            end
        end else begin
            if (pos_q == '0) begin
                pos_adv_d = POS_W'(1);
                dir_adv_d = 1'b0;
            end else begin
                pos_adv_d = pos_q - POS_W'(1);
            end
        end
    end

    // Internal direction flag follows every advance.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            dir_q <= 1'b0;
        end else if (adv_en_d) begin
            dir_q <= dir_adv_d;
        end
    end
`else
    logic dir_s1_q, dir_s2_q;

    // Direction switch synchroniser.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            dir_s1_q <= 1'b0;
            dir_s2_q <= 1'b0;
        end else begin
            dir_s1_q <= bus.dir_sw;
            dir_s2_q <= dir_s1_q;
        end
    end

    // Wrap-around advance, direction taken from the switch in the advance cycle.
    always_comb begin
        pos_adv_d = pos_q;
        if (!dir_s2_q) begin
            pos_adv_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end else begin
            pos_adv_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
        end
    end
`endif

    // Scroll FSM with registered pos/tick/prescaler.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_PAUSED;
            pos_q   <= '0;
            tick_q  <= 1'b0;
            pre_q   <= '0;
        end else begin
            case (state_q)
                ST_PAUSED: begin
                    pre_q  <= '0;
                    tick_q <= 1'b0;
                    if (run_s2_q) begin
                        state_q <= ST_RUNNING;
                    end else if (step_edge_q) begin
                        state_q <= ST_STEP;
                        pos_q   <= pos_adv_d;
                        tick_q  <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (!run_s2_q) begin
                        // Pausing wins over a coincident wrap: no tick, pos held.
                        state_q <= ST_PAUSED;
                        pre_q   <= '0;
                        tick_q  <= 1'b0;
                    end else if (wrap_d) begin
                        pre_q  <= '0;
                        pos_q  <= pos_adv_d;
                        tick_q <= 1'b1;
                    end else begin
                        pre_q  <= pre_q + PRE_W'(1);
                        tick_q <= 1'b0;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_PAUSED;
                    pre_q   <= '0;
                    tick_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_PAUSED;
                    pre_q   <= '0;
                    tick_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pos   = pos_q;
    assign bus.tick  = tick_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Bench for hello_scroll_ctrl with TICK_CYCLES=10: directed stimulus, scoreboard of expected ticks.
// Latency: expected entries carry the cycle gap since the previous tick or RUNNING entry.
// Backpressure: none; every tick seen pops one expected entry.
`timescale 1ns/1ps
module tb_hello_scroll_ctrl;
    localparam int TICK_CYCLES = 10;
    localparam int NPOS        = 8;
    localparam int POS_W       = 4;
    localparam int PRE_W       = 26;

    typedef struct {
        int pos;
        int st;
        int gap;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_ref = 0;
    logic [1:0] prev_st = 2'b00;
    exp_t sbq[$];

    int fwd_exp[8];
    int rev_exp[2];
    int spd_exp[4];
    int stp_exp[2];
    int paused_pos, runstep_pos, hold_pos, raise_pos;

    hello_scroll_ctrl_if #(.POS_W(POS_W)) bus ();

    hello_scroll_ctrl #(
        .TICK_CYCLES(TICK_CYCLES),
        .NPOS       (NPOS),
        .POS_W      (POS_W),
        .PRE_W      (PRE_W)
    ) dut (
        .CLOCK_50(clk),
        .Resetn  (resetn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic push(input int p, input int s, input int g);
        exp_t e;
        e.pos = p;
        e.st  = s;
        e.gap = g;
        sbq.push_back(e);
    endtask

    task automatic wait_tick(input int maxc, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (bus.tick) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s no tick within %0d cycles", nm, maxc);
        end
    endtask

    // Monitor: every tick is matched against the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!resetn) begin
            prev_st = 2'b00;
        end else begin
            if (bus.state == 2'b01 && prev_st != 2'b01) last_ref = cyc;
            if (bus.tick) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_tick pos=%0d state=%0d", bus.pos, bus.state);
                end else begin
                    e = sbq.pop_front();
                    if (int'(bus.pos) != e.pos || int'(bus.state) != e.st ||
                        (e.gap != 0 && (cyc - last_ref) != e.gap)) begin
                        bad++;
                        $display("FAIL tick_chk got pos=%0d st=%0d gap=%0d want pos=%0d st=%0d gap=%0d",
                                 bus.pos, bus.state, cyc - last_ref, e.pos, e.st, e.gap);
                    end
                end
                last_ref = cyc;
            end
            prev_st = bus.state;
        end
    end

    initial begin
`ifdef HELLO_SCROLL_BOUNCE_EN
        fwd_exp = '{1, 2, 3, 4, 5, 6, 7, 6};
        rev_exp = '{5, 4};
        spd_exp = '{3, 2, 1, 0};
        stp_exp = '{1, 2};
        paused_pos = 0; runstep_pos = 3; hold_pos = 3; raise_pos = 4;
`else
        fwd_exp = '{1, 2, 3, 4, 5, 6, 7, 0};
        rev_exp = '{7, 6};
        spd_exp = '{5, 4, 3, 2};
        stp_exp = '{3, 4};
        paused_pos = 2; runstep_pos = 5; hold_pos = 5; raise_pos = 6;
`endif
        bus.run_sw     = 1'b1;
        bus.dir_sw     = 1'b0;
        bus.speed      = 2'b00;
        bus.step_key_n = 1'b1;
        resetn         = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pos", bus.pos, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_state", bus.state, 0);

        // Release with run held high; forward scrolling at speed 0
        for (int i = 0; i < 8; i++) push(fwd_exp[i], 1, 10);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.state == 2'b01) break;
        end
        check("run_entry_state", bus.state, 1);
        for (int i = 0; i < 8; i++) wait_tick(15, "fwd_tick");

        // Reverse from here
        bus.dir_sw = 1'b1;
        for (int i = 0; i < 2; i++) push(rev_exp[i], 1, 10);
        for (int i = 0; i < 2; i++) wait_tick(15, "rev_tick");

        // Speed-up lands when prescaler is 6: wrap next cycle, then every 2 cycles
        push(spd_exp[0], 1, 7);
        for (int i = 1; i < 4; i++) push(spd_exp[i], 1, 2);
        repeat (4) @(negedge clk);
        bus.speed = 2'd2;
        for (int i = 0; i < 3; i++) wait_tick(10, "spd_tick");
        // Run drop still lets one more tick through the synchroniser
        bus.run_sw = 1'b0;
        bus.speed  = 2'd0;
        bus.dir_sw = 1'b0;
        wait_tick(5, "spd_last_tick");
        repeat (3) @(negedge clk);
        check("paused_state", bus.state, 0);
        check("paused_pos", bus.pos, paused_pos);

        // Single steps from a long press, two presses
        for (int k = 0; k < 2; k++) begin
            push(stp_exp[k], 2, 0);
            bus.step_key_n = 1'b0;
            wait_tick(10, "step_tick");
            @(negedge clk);
            check("step_back_state", bus.state, 0);
            check("step_back_tick", bus.tick, 0);
            repeat (15) @(negedge clk);
            bus.step_key_n = 1'b1;
            repeat (5) @(negedge clk);
        end
        check("step_pos_held", bus.pos, stp_exp[1]);

        // Press while running is ignored; normal tick 10 cycles after entry
        push(runstep_pos, 1, 10);
        bus.run_sw = 1'b1;
        repeat (3) @(negedge clk);
        check("rerun_state", bus.state, 1);
        bus.step_key_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.step_key_n = 1'b1;
        wait_tick(15, "runstep_tick");

        // Drop run so the pause coincides with prescaler 6
        repeat (4) @(negedge clk);
        bus.run_sw = 1'b0;
        repeat (8) @(negedge clk);
        check("drop_state", bus.state, 0);
        check("drop_pos", bus.pos, hold_pos);
        check("drop_tick", bus.tick, 0);

        // Raise again: tick exactly 10 cycles after re-entering RUNNING
        push(raise_pos, 1, 10);
        bus.run_sw = 1'b1;
        wait_tick(20, "raise_tick");

        // Asynchronous reset while running with tick high
        #2 resetn = 1'b0;
        #1;
        check("arst_pos", bus.pos, 0);
        check("arst_tick", bus.tick, 0);
        check("arst_state", bus.state, 0);
        repeat (2) @(negedge clk);
        check("sb_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
